// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the registered priority encoder.
// Default build is 8 inputs and a 3-bit index.
package encoder_pkg;

    localparam int ENC_N_IN  = 8;
    localparam int ENC_OUT_W = 3;

    // True when two or more bits of vec are set.
    function automatic logic onehot_multi(input logic [ENC_N_IN-1:0] vec);
        return |(vec & (vec - {{(ENC_N_IN-1){1'b0}}, 1'b1}));
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: winning-bit index, any-set and multi-set flags.
// Zero latency; no flow control, every input value maps to a defined output.
module prio_enc_comb
    import encoder_pkg::*;
#(
    parameter int N_IN         = ENC_N_IN,
    parameter bit MSB_PRIORITY = 1'b1,
    localparam int OUT_W       = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  d,
    output logic [OUT_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Scan order decides the winner: the last set bit visited overwrites idx.
    always_comb begin
        idx = '0;
        if (MSB_PRIORITY) begin
            for (int i = 0; i < N_IN; i++) begin
                if (d[i]) idx = OUT_W'(i);
            end
        end else begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (d[i]) idx = OUT_W'(i);
            end
        end
    end

    assign any = |d;

    generate
        if (N_IN == ENC_N_IN) begin : g_pkg_multi
            assign multi = onehot_multi(d);
        end else begin : g_gen_multi
            assign multi = |(d & (d - {{(N_IN-1){1'b0}}, 1'b1}));
        end
    endgenerate

endmodule

// File: rtl/encoder_8by3_sync.sv
// Registered priority encoder, one cycle from d to out/valid/multi_hot.
// en low holds all outputs; rst clears them asynchronously and overrides en.
module encoder_8by3_sync
    import encoder_pkg::*;
#(
    parameter int N_IN         = ENC_N_IN,
    parameter bit MSB_PRIORITY = 1'b1,
    localparam int OUT_W       = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_IN-1:0]  d,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic             multi_hot
);

    logic [OUT_W-1:0] w_idx;
    logic             w_any;
    logic             w_multi;

    logic [OUT_W-1:0] r_out;
    logic             r_valid;
    logic             r_multi_hot;

    prio_enc_comb #(
        .N_IN         (N_IN),
        .MSB_PRIORITY (MSB_PRIORITY)
    ) u_prio_enc_comb (
        .d     (d),
        .idx   (w_idx),
        .any   (w_any),
        .multi (w_multi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_valid     <= 1'b0;
            r_multi_hot <= 1'b0;
        end else if (en) begin
            r_out       <= w_idx;
            r_valid     <= w_any;
            r_multi_hot <= w_multi;
        end
    end

    assign out       = r_out;
    assign valid     = r_valid;
    assign multi_hot = r_multi_hot;

endmodule

// File: tb/tb_encoder_8by3_sync.sv
// Bench for encoder_8by3_sync: MSB- and LSB-priority instances driven in parallel.
module tb_encoder_8by3_sync;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] d;

    logic [2:0] m_out, l_out;
    logic       m_valid, l_valid, m_multi, l_multi;

    int tests;
    int fails;

    encoder_8by3_sync #(.N_IN(8), .MSB_PRIORITY(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .en(en), .d(d),
        .out(m_out), .valid(m_valid), .multi_hot(m_multi)
    );

    encoder_8by3_sync #(.N_IN(8), .MSB_PRIORITY(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .en(en), .d(d),
        .out(l_out), .valid(l_valid), .multi_hot(l_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {index, any, multi} from plain arithmetic on the value.
    function automatic logic [4:0] ref_enc(input logic [7:0] v, input bit msb);
        int t;
        int idx;
        idx = 0;
        if (msb) t = int'(v);
        else     t = int'(v) & -int'(v);
        while (t > 1) begin
            t   = t / 2;
            idx = idx + 1;
        end
        return {idx[2:0], (v != 8'd0), ($countones(v) > 1)};
    endfunction

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic [7:0] dv, input logic env);
        @(negedge clk);
        d  = dv;
        en = env;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [4:0] e;
        @(negedge clk);
        rst = 1'b1; en = 1'b1; d = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({m_out, m_valid, m_multi} !== 5'b0) begin
            fails++;
            $display("FAIL reset_msb got=%b want=%b", {m_out, m_valid, m_multi}, 5'b0);
        end
        tests++;
        if ({l_out, l_valid, l_multi} !== 5'b0) begin
            fails++;
            $display("FAIL reset_lsb got=%b want=%b", {l_out, l_valid, l_multi}, 5'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        step(8'hFF, 1'b1);
        e = ref_enc(8'hFF, 1'b1);
        tests++;
        if ({m_out, m_valid, m_multi} !== e) begin
            fails++;
            $display("FAIL first_capture got=%b want=%b", {m_out, m_valid, m_multi}, e);
        end
        // Assert rst between edges: outputs must clear before the next edge.
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({m_out, m_valid, m_multi, l_out, l_valid, l_multi} !== 10'b0) begin
            fails++;
            $display("FAIL async_reset got=%b want=%b",
                     {m_out, m_valid, m_multi, l_out, l_valid, l_multi}, 10'b0);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({m_out, m_valid, m_multi} !== 5'b0) begin
            fails++;
            $display("FAIL reset_over_en got=%b want=%b", {m_out, m_valid, m_multi}, 5'b0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_onehot;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] v;
            logic [2:0] want;
            v    = 8'd1 << i;
            want = 3'(i);
            step(v, 1'b1);
            tests++;
            if ({m_out, m_valid, m_multi} !== {want, 2'b10}) begin
                fails++;
                $display("FAIL onehot_msb d=%h got=%b want=%b", v, {m_out, m_valid, m_multi}, {want, 2'b10});
            end
            tests++;
            if ({l_out, l_valid, l_multi} !== {want, 2'b10}) begin
                fails++;
                $display("FAIL onehot_lsb d=%h got=%b want=%b", v, {l_out, l_valid, l_multi}, {want, 2'b10});
            end
        end
    endtask

    task automatic test_zero;
        step(8'h00, 1'b1);
        tests++;
        if ({m_out, m_valid, m_multi, l_out, l_valid, l_multi} !== 10'b0) begin
            fails++;
            $display("FAIL zero got=%b want=%b", {m_out, m_valid, m_multi, l_out, l_valid, l_multi}, 10'b0);
        end
    endtask

    task automatic test_multi;
        step(8'b0010_0110, 1'b1);
        tests++;
        if ({m_out, m_valid, m_multi} !== 5'b101_11) begin
            fails++;
            $display("FAIL multi_msb got=%b want=%b", {m_out, m_valid, m_multi}, 5'b101_11);
        end
        tests++;
        if ({l_out, l_valid, l_multi} !== 5'b001_11) begin
            fails++;
            $display("FAIL multi_lsb got=%b want=%b", {l_out, l_valid, l_multi}, 5'b001_11);
        end
        step(8'hFF, 1'b1);
        tests++;
        if ({m_out, m_valid, m_multi} !== 5'b111_11) begin
            fails++;
            $display("FAIL all_ones_msb got=%b want=%b", {m_out, m_valid, m_multi}, 5'b111_11);
        end
        tests++;
        if ({l_out, l_valid, l_multi} !== 5'b000_11) begin
            fails++;
            $display("FAIL all_ones_lsb got=%b want=%b", {l_out, l_valid, l_multi}, 5'b000_11);
        end
    endtask

    task automatic test_enable;
        step(8'h10, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(8'h02, 1'b0);
            tests++;
            if ({m_out, m_valid, m_multi} !== 5'b100_10) begin
                fails++;
                $display("FAIL enable_hold cyc=%0d got=%b want=%b", c, {m_out, m_valid, m_multi}, 5'b100_10);
            end
        end
        step(8'h02, 1'b1);
        tests++;
        if ({m_out, m_valid, m_multi} !== 5'b001_10) begin
            fails++;
            $display("FAIL enable_resume got=%b want=%b", {m_out, m_valid, m_multi}, 5'b001_10);
        end
    endtask

    task automatic test_exhaustive;
        for (int v = 0; v < 256; v++) begin
            logic [7:0] dv;
            logic [4:0] em, el;
            dv = 8'(v);
            em = ref_enc(dv, 1'b1);
            el = ref_enc(dv, 1'b0);
            step(dv, 1'b1);
            tests++;
            if ({m_out, m_valid, m_multi} !== em) begin
                fails++;
                $display("FAIL exh_msb d=%h got=%b want=%b", dv, {m_out, m_valid, m_multi}, em);
            end
            tests++;
            if ({l_out, l_valid, l_multi} !== el) begin
                fails++;
                $display("FAIL exh_lsb d=%h got=%b want=%b", dv, {l_out, l_valid, l_multi}, el);
            end
        end
    endtask

    task automatic test_random;
        logic [4:0] em, el;
        em = {m_out, m_valid, m_multi} === 5'bx ? 5'b0 : ref_enc(8'h02, 1'b1);
        el = ref_enc(8'h02, 1'b0);
        // Last capture from the exhaustive sweep was 8'hFF.
        em = ref_enc(8'hFF, 1'b1);
        el = ref_enc(8'hFF, 1'b0);
        for (int c = 0; c < 300; c++) begin
            logic [7:0] dv;
            logic       ev;
            dv = 8'($urandom);
            ev = ($urandom_range(0, 3) != 0);
            if (ev) begin
                em = ref_enc(dv, 1'b1);
                el = ref_enc(dv, 1'b0);
            end
            step(dv, ev);
            tests++;
            if ({m_out, m_valid, m_multi} !== em) begin
                fails++;
                $display("FAIL rand_msb d=%h en=%b got=%b want=%b", dv, ev, {m_out, m_valid, m_multi}, em);
            end
            tests++;
            if ({l_out, l_valid, l_multi} !== el) begin
                fails++;
                $display("FAIL rand_lsb d=%h en=%b got=%b want=%b", dv, ev, {l_out, l_valid, l_multi}, el);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        en    = 1'b0;
        d     = 8'h00;
        test_reset;
        test_onehot;
        test_zero;
        test_multi;
        test_enable;
        test_exhaustive;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
